// File: rtl/bcd_counter_ndigit_if.sv
// Control/data bundle for bcd_counter_ndigit: count controls, load value, count and terminal-count outputs.
// The counter takes the slave modport; whatever drives the controls takes master.
interface bcd_counter_ndigit_if #(
  parameter int DIGITS = 2
);
  logic                  En;
  logic                  Up;
  logic                  Ld;
  logic [4*DIGITS-1:0]   D;
  logic [4*DIGITS-1:0]   O;
  logic                  Co;

  modport master (
    output En,
    output Up,
    output Ld,
    output D,
    input  O,
    input  Co
  );

  modport slave (
    input  En,
    input  Up,
    input  Ld,
    input  D,
    output O,
    output Co
  );
endinterface

// File: rtl/bcd_counter_ndigit.sv
// N-digit up/down BCD counter with sanitising parallel load and combinational terminal count.
// Optional macro BCD_COUNTER_SATURATE_EN makes counting saturate at all-9s/all-0s instead of wrapping.
module bcd_counter_ndigit #(
  parameter int DIGITS = 2
) (
  input  logic                 Clk,
  input  logic                 R,
  bcd_counter_ndigit_if.slave  bus
);

  localparam int W = 4 * DIGITS;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_counter_ndigit: DIGITS must be in 1..8");
  end

  logic [W-1:0]    cnt;
  logic [W-1:0]    cnt_nxt;
  logic [W-1:0]    load_val;
  logic [W-1:0]    inc_val;
  logic [W-1:0]    dec_val;
  logic [DIGITS:0] low9;
  logic [DIGITS:0] low0;
  logic            all9;
  logic            all0;
  logic            terminal;

  // low9[i] / low0[i]: every digit below i is 9 / 0, i.e. digit i carries / borrows.
  always_comb begin
    low9     = '0;
    low0     = '0;
    inc_val  = cnt;
    dec_val  = cnt;
    load_val = '0;
    low9[0]  = 1'b1;
    low0[0]  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      low9[i+1] = low9[i] & (cnt[4*i +: 4] == 4'd9);
      low0[i+1] = low0[i] & (cnt[4*i +: 4] == 4'd0);
      if (low9[i]) begin
        inc_val[4*i +: 4] = (cnt[4*i +: 4] == 4'd9) ? 4'd0 : cnt[4*i +: 4] + 4'd1;
      end
      if (low0[i]) begin
        dec_val[4*i +: 4] = (cnt[4*i +: 4] == 4'd0) ? 4'd9 : cnt[4*i +: 4] - 4'd1;
      end
      load_val[4*i +: 4] = (bus.D[4*i +: 4] > 4'd9) ? 4'd9 : bus.D[4*i +: 4];
    end
  end

  assign all9     = low9[DIGITS];
  assign all0     = low0[DIGITS];
  assign terminal = bus.Up ? all9 : all0;

  always_comb begin
    cnt_nxt = cnt;
    if (bus.Ld) begin
      cnt_nxt = load_val;
    end else if (bus.En) begin
`ifdef BCD_COUNTER_SATURATE_EN
      if (!terminal) begin
        cnt_nxt = bus.Up ? inc_val : dec_val;
      end
`else
      cnt_nxt = bus.Up ? inc_val : dec_val;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (R) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign bus.O  = cnt;
  assign bus.Co = bus.En & ~bus.Ld & ~R & terminal;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Bench for bcd_counter_ndigit (DIGITS=2): directed vector table, hand-written sequences,
// then random stimulus against a decimal-integer reference model.
module tb_bcd_counter_ndigit;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 99;
`ifdef BCD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic         r;
    logic         ld;
    logic         en;
    logic         up;
    logic [W-1:0] d;
    logic         exp_co;
    logic [W-1:0] exp_o;
  } vec_t;

  logic Clk = 1'b0;
  logic R;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  bcd_counter_ndigit_if #(.DIGITS(DIGITS)) bus ();

  bcd_counter_ndigit #(.DIGITS(DIGITS)) dut (
    .Clk (Clk),
    .R   (R),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model works on the decimal value, not on nibbles.
  function automatic int sanitize(input logic [W-1:0] d);
    int v = 0;
    int p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int nib = int'(d[4*i +: 4]);
      v += ((nib > 9) ? 9 : nib) * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] b = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  function automatic int model_next(input int v, input logic r, ld, en, up, input logic [W-1:0] d);
    if (r) return 0;
    if (ld) return sanitize(d);
    if (!en) return v;
    if (up) return (v == MAXV) ? (SAT ? MAXV : 0) : v + 1;
    return (v == 0) ? (SAT ? 0 : MAXV) : v - 1;
  endfunction

  function automatic logic model_co(input int v, input logic r, ld, en, up);
    return en && !ld && !r && ((up && v == MAXV) || (!up && v == 0));
  endfunction

  // Inputs are driven just after a rising edge; Co is sampled at the falling edge, O after the next rising edge.
  task automatic apply(input string nm, input logic r, ld, en, up, input logic [W-1:0] d,
                       input logic exp_co, input logic [W-1:0] exp_o);
    R      = r;
    bus.Ld = ld;
    bus.En = en;
    bus.Up = up;
    bus.D  = d;
    @(negedge Clk);
    chk({nm, " Co"}, 32'(bus.Co), 32'(exp_co));
    @(posedge Clk);
    #1;
    chk({nm, " O"}, 32'(bus.O), 32'(exp_o));
  endtask

  // Drives one cycle and checks against the model, advancing the model value.
  task automatic model_step(input string nm, inout int v, input logic r, ld, en, up, input logic [W-1:0] d);
    logic co_e;
    co_e = model_co(v, r, ld, en, up);
    v    = model_next(v, r, ld, en, up, d);
    apply(nm, r, ld, en, up, d, co_e, to_bcd(v));
  endtask

  initial begin
    int v;
    R      = 1'b1;
    bus.Ld = 1'b0;
    bus.En = 1'b0;
    bus.Up = 1'b1;
    bus.D  = '0;

    //                r     ld    en    up    d      co                  o
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0,              8'h00});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0,              8'h00});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h5C, 1'b0,              8'h59});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 8'h37, 1'b0,              8'h37});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 1'b0,              8'h42});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0,            8'h42});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0,              8'h10});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0,              8'h09});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0,              8'h10});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 1'b0,              8'h99});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1,              SAT ? 8'h99 : 8'h00});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, SAT ? 1'b0 : 1'b1, SAT ? 8'h98 : 8'h99});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0,              SAT ? 8'h98 : 8'h99});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0,              8'h99});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0,              8'h90});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0,              8'h00});

    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("vec%0d", i), tbl[i].r, tbl[i].ld, tbl[i].en, tbl[i].up,
            tbl[i].d, tbl[i].exp_co, tbl[i].exp_o);
    end

    // Reset for 3 edges, then 100 up-counts: 00..99 and (wrap build) back to 00.
    v = 0;
    for (int i = 0; i < 3; i++) model_step("up_rst", v, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 100; i++) begin
      chk("up_seq_pre", 32'(bus.O), 32'(to_bcd(SAT ? ((i > MAXV) ? MAXV : i) : i % 100)));
      model_step("up_cnt", v, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    end

    // Reset then down-count: 00, 99, 98 ... 89.
    model_step("dn_rst", v, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 11; i++) model_step("dn_cnt", v, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("dn_final", 32'(bus.O), 32'(SAT ? 8'h00 : 8'h89));

    // Terminal approach from 98: 99, 99, 99, 99 when saturating; 99, 00, 01, 02 when wrapping.
    model_step("sat_ld", v, 1'b0, 1'b1, 1'b0, 1'b1, 8'h98);
    for (int i = 0; i < 4; i++) model_step("sat_cnt", v, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    chk("sat_final", 32'(bus.O), 32'(SAT ? 8'h99 : 8'h02));

    // Random traffic, including non-BCD load values and mid-count resets.
    model_step("rnd_rst", v, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 600; i++) begin
      logic r, ld, en, up;
      logic [W-1:0] d;
      r  = ($urandom_range(0, 29) == 0);
      ld = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 3) != 0);
      up = ($urandom_range(0, 5) < 3);
      d  = W'($urandom);
      model_step("rnd", v, r, ld, en, up, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
